// File: rtl/muxn_rr_reg.sv
// muxn_rr_reg: NUM_CH-to-1 registered multiplexer with valid/ready handshakes.
// A round-robin pointer picks the next valid channel. The chosen word and its
// channel index are captured in a single output register stage.
// Optional build macro: MUXN_RR_FIXED_PRIO_EN removes the round-robin pointer,
// so channel 0 always has the highest priority.
module muxn_rr_reg #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic [NUM_CH-1:0]        in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_sel,
  input  logic                     out_ready
);

  localparam int unsigned NCH_U = NUM_CH;

  logic              load_en;
  logic              gnt_found;
  logic [SEL_W-1:0]  gnt_idx;
  logic [DATA_W-1:0] gnt_data;
  logic [SEL_W-1:0]  start_idx;

  assign load_en = !out_valid || out_ready;

`ifdef MUXN_RR_FIXED_PRIO_EN
  assign start_idx = '0;
`else
  logic [SEL_W-1:0] ptr;

  assign start_idx = ptr;

  // Advance the pointer past the granted channel on each transfer. The wrap
  // is an explicit compare, so it stays in range for any NUM_CH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (load_en && gnt_found) begin
      ptr <= (gnt_idx == SEL_W'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end
`endif

  // Pick the first valid channel, starting at start_idx and wrapping.
  always_comb begin
    int unsigned idx;
    logic [SEL_W-1:0] idx_sel;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    gnt_data  = '0;
    idx       = 0;
    idx_sel   = '0;
    for (int unsigned k = 0; k < NCH_U; k++) begin
      idx = int'(start_idx) + k;
      if (idx >= NCH_U) idx = idx - NCH_U;
      idx_sel = idx[SEL_W-1:0];
      if (!gnt_found && in_valid[idx_sel]) begin
        gnt_found = 1'b1;
        gnt_idx   = idx_sel;
        gnt_data  = in_data[idx*DATA_W +: DATA_W];
      end
    end
  end

  // Only the granted channel sees ready, and only when the register can load.
  always_comb begin
    in_ready = '0;
    if (rst_n && load_en && gnt_found) in_ready[gnt_idx] = 1'b1;
  end

  // Output register: load on grant, drain to empty when there is no grant,
  // hold everything on stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else if (load_en) begin
      if (gnt_found) begin
        out_valid <= 1'b1;
        out_data  <= gnt_data;
        out_sel   <= gnt_idx;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_muxn_rr_reg.sv
// Testbench for muxn_rr_reg: directed vector table, reset and wrap sequences,
// plus randomized traffic checked against a behavioural arbitration model.
module tb_muxn_rr_reg;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 4-channel instance
  logic [3:0]  v4 = '0;
  logic [31:0] d4 = '0;
  logic        r4 = 1'b0;
  logic [3:0]  ir4;
  logic        ov4;
  logic [7:0]  od4;
  logic [1:0]  os4;

  // 3-channel instance
  logic [2:0]  v3 = '0;
  logic [23:0] d3 = '0;
  logic        r3 = 1'b0;
  logic [2:0]  ir3;
  logic        ov3;
  logic [7:0]  od3;
  logic [1:0]  os3;

  muxn_rr_reg #(.NUM_CH(4), .DATA_W(8)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_data(d4), .in_ready(ir4),
    .out_valid(ov4), .out_data(od4), .out_sel(os4), .out_ready(r4)
  );

  muxn_rr_reg #(.NUM_CH(3), .DATA_W(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(v3), .in_data(d3), .in_ready(ir3),
    .out_valid(ov3), .out_data(od3), .out_sel(os3), .out_ready(r3)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  v;
    logic [31:0] d;
    logic        r;
    logic [3:0]  ir;
    logic        ov;
    logic [7:0]  od;
    logic [1:0]  os;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic [3:0] v, input logic [31:0] d, input logic r,
                              input logic [3:0] ir, input logic ov, input logic [7:0] od,
                              input logic [1:0] os);
    vec_t e;
    e.v = v; e.d = d; e.r = r; e.ir = ir; e.ov = ov; e.od = od; e.os = os;
    tbl.push_back(e);
  endfunction

  localparam logic [31:0] ALL_D = 32'h1312_1110;
  localparam logic [31:0] A5_D  = 32'h00A5_0000;

  // Behavioural model state for the random phase
  logic       mov;
  logic [7:0] mod;
  int         mos;
  int         mptr;
  logic [3:0] pv;
  logic [7:0] pdat [4];

  initial begin
    // ---------- vector table (issued right after reset, pointer at 0) ----------
`ifdef MUXN_RR_FIXED_PRIO_EN
    for (int i = 0; i < 6; i++) add(4'hF, ALL_D, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0);
    for (int i = 0; i < 3; i++) add(4'hF, ALL_D, 1'b0, 4'b0000, 1'b1, 8'h10, 2'd0);
    add(4'hF, ALL_D, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0);
    add(4'h0, ALL_D, 1'b1, 4'b0000, 1'b0, 8'h10, 2'd0);
    add(4'h0, ALL_D, 1'b0, 4'b0000, 1'b0, 8'h10, 2'd0);
`else
    add(4'hF, ALL_D, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0);
    add(4'hF, ALL_D, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1);
    add(4'hF, ALL_D, 1'b1, 4'b0100, 1'b1, 8'h12, 2'd2);
    add(4'hF, ALL_D, 1'b1, 4'b1000, 1'b1, 8'h13, 2'd3);
    add(4'hF, ALL_D, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0);
    add(4'hF, ALL_D, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1);
    for (int i = 0; i < 3; i++) add(4'hF, ALL_D, 1'b0, 4'b0000, 1'b1, 8'h11, 2'd1);
    add(4'hF, ALL_D, 1'b1, 4'b0100, 1'b1, 8'h12, 2'd2);
    add(4'h0, ALL_D, 1'b1, 4'b0000, 1'b0, 8'h12, 2'd2);
    add(4'h0, ALL_D, 1'b0, 4'b0000, 1'b0, 8'h12, 2'd2);
`endif
    add(4'b0100, A5_D, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2);
    add(4'b0000, A5_D, 1'b1, 4'b0000, 1'b0, 8'hA5, 2'd2);

    // ---------- reset state ----------
    repeat (2) @(negedge clk);
    chk("rst_ov4", ov4, 0);
    chk("rst_od4", od4, 0);
    chk("rst_os4", os4, 0);
    chk("rst_ir4", ir4, 0);
    v4 = 4'hF; d4 = ALL_D; r4 = 1'b1;
    #1 chk("rst_ir4_valid", ir4, 0);
    v4 = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // ---------- 3-channel wrap: only ch0 and ch2 valid ----------
    v3 = 3'b101; d3 = 24'hC2_00C0; r3 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      int g;
`ifdef MUXN_RR_FIXED_PRIO_EN
      g = 0;
`else
      g = (i % 2 == 0) ? 0 : 2;
`endif
      #1 chk($sformatf("wrap3_ir[%0d]", i), ir3, 32'(1 << g));
      @(posedge clk);
      #1;
      chk($sformatf("wrap3_ov[%0d]", i), ov3, 1);
      chk($sformatf("wrap3_os[%0d]", i), os3, g);
      chk($sformatf("wrap3_od[%0d]", i), od3, (g == 0) ? 32'hC0 : 32'hC2);
      @(negedge clk);
    end
    v3 = '0; r3 = 1'b0;
    @(negedge clk);
    // Re-reset so the 4-channel table starts with the pointer at 0
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // ---------- vector table on the 4-channel instance ----------
    for (int i = 0; i < tbl.size(); i++) begin
      v4 = tbl[i].v; d4 = tbl[i].d; r4 = tbl[i].r;
      #1 chk($sformatf("tbl_ir[%0d]", i), ir4, tbl[i].ir);
      @(posedge clk);
      #1;
      chk($sformatf("tbl_ov[%0d]", i), ov4, tbl[i].ov);
      chk($sformatf("tbl_od[%0d]", i), od4, tbl[i].od);
      chk($sformatf("tbl_os[%0d]", i), os4, tbl[i].os);
      @(negedge clk);
    end

    // ---------- asynchronous reset mid-stream ----------
    v4 = 4'hF; d4 = ALL_D; r4 = 1'b1;
    @(posedge clk);
    @(posedge clk);
    r4 = 1'b0;
    #3;
    chk("mid_pre_ov", ov4, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ov", ov4, 0);
    chk("mid_rst_os", os4, 0);
    chk("mid_rst_ir", ir4, 0);
    @(negedge clk);
    rst_n = 1'b1;
    r4 = 1'b1;
    #1 chk("post_rst_ir", ir4, 4'b0001);
    @(posedge clk);
    #1;
    chk("post_rst_os", os4, 0);
    chk("post_rst_ov", ov4, 1);
    @(negedge clk);
    v4 = '0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // ---------- randomized traffic vs behavioural model ----------
    mov = 1'b0; mod = '0; mos = 0; mptr = 0; pv = '0;
    for (int c = 0; c < 4; c++) pdat[c] = 8'h00;
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic load, found;
      int g;
      logic [3:0] exp_ir;
      v4 = pv;
      for (int c = 0; c < 4; c++) d4[c*8 +: 8] = pdat[c];
      r4 = ($urandom_range(0, 3) != 0);
      load = !mov || r4;
      found = 1'b0;
      g = 0;
      for (int k = 0; k < 4; k++) begin
        int c;
        c = (mptr + k) % 4;
        if (!found && pv[c]) begin found = 1'b1; g = c; end
      end
      exp_ir = (load && found) ? 4'(1 << g) : 4'b0000;
      #1 chk($sformatf("rnd_ir[%0d]", cyc), ir4, exp_ir);
      @(posedge clk);
      if (load) begin
        if (found) begin
          mov = 1'b1; mod = pdat[g]; mos = g;
`ifndef MUXN_RR_FIXED_PRIO_EN
          mptr = (g + 1) % 4;
`endif
          pv[g] = 1'b0;
        end else begin
          mov = 1'b0;
        end
      end
      for (int c = 0; c < 4; c++) begin
        if (!pv[c] && ($urandom_range(0, 2) != 0)) begin
          pv[c] = 1'b1;
          pdat[c] = 8'($urandom);
        end
      end
      #1;
      chk($sformatf("rnd_ov[%0d]", cyc), ov4, mov);
      chk($sformatf("rnd_od[%0d]", cyc), od4, mod);
      chk($sformatf("rnd_os[%0d]", cyc), os4, mos);
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
